// File: rtl/logic_reduce_pkg.sv
// Shared definitions for the pipelined bitwise reduction unit: operator encodings
// and compile-time helpers that size the reduction tree.
package logic_reduce_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned span;
    res  = 0;
    span = 1;
    while (span < value) begin
      span = span * 2;
      res++;
    end
    return res;
  endfunction

  // Partial count held at tree level `level`; level 0 is the raw operand set.
  function automatic int unsigned level_count(input int unsigned n, input int unsigned level);
    int unsigned cnt;
    cnt = n;
    for (int unsigned j = 0; j < level; j++) begin
      cnt = (cnt + 1) / 2;
    end
    return cnt;
  endfunction

  // Partial-count offset of level `level` inside a bus holding all levels back to back.
  function automatic int unsigned level_offset(input int unsigned n, input int unsigned level);
    int unsigned off;
    off = 0;
    for (int unsigned j = 0; j < level; j++) begin
      off += level_count(n, j);
    end
    return off;
  endfunction

endpackage

// File: rtl/reduce_level.sv
// One registered level of the reduction tree: pairs adjacent partials, holds the
// result with its valid bit and operator, and applies the XNOR inversion when LAST.
module reduce_level
  import logic_reduce_pkg::*;
#(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned IN_COUNT = 2,
  parameter bit          LAST     = 1'b0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [IN_COUNT*WIDTH-1:0]            in_data_i,
  input  logic [1:0]                           in_op_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  output logic [((IN_COUNT+1)/2)*WIDTH-1:0]    out_data_o,
  output logic [1:0]                           out_op_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i
);

  localparam int unsigned OutCount = (IN_COUNT + 1) / 2;

  logic [OutCount*WIDTH-1:0] pair_flat;
  logic [OutCount*WIDTH-1:0] data_d, data_q;
  logic [1:0]                op_q;
  logic                      valid_q;

  for (genvar g = 0; g < OutCount; g++) begin : g_pair
    if (2 * g + 1 < IN_COUNT) begin : g_two
      logic [WIDTH-1:0] a, b;
      assign a = in_data_i[(2*g)*WIDTH +: WIDTH];
      assign b = in_data_i[(2*g+1)*WIDTH +: WIDTH];
      // XNOR pairs as XOR; the single inversion happens at the final level.
      assign pair_flat[g*WIDTH +: WIDTH] = (in_op_i == OP_AND) ? (a & b) :
                                           (in_op_i == OP_OR)  ? (a | b) : (a ^ b);
    end else begin : g_one
      assign pair_flat[g*WIDTH +: WIDTH] = in_data_i[(2*g)*WIDTH +: WIDTH];
    end
  end

  assign data_d     = (LAST && (in_op_i == OP_XNOR)) ? ~pair_flat : pair_flat;
  assign in_ready_o = !valid_q || out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      op_q    <= OP_AND;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        data_q <= data_d;
        op_q   <= in_op_i;
      end
    end
  end

  assign out_data_o  = data_q;
  assign out_op_o    = op_q;
  assign out_valid_o = valid_q;

endmodule

// File: rtl/logic_reduce_pipe.sv
// Pipelined N-operand bitwise reduction (AND/OR/XOR/XNOR) with one registered tree
// level per cycle and valid/ready flow control on both sides.
module logic_reduce_pipe
  import logic_reduce_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned N     = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N*WIDTH-1:0]   I,
  input  logic [1:0]           OP,
  input  logic                 I_valid,
  output logic                 I_ready,
  output logic [WIDTH-1:0]     O,
  output logic                 O_valid,
  input  logic                 O_ready
);

  localparam int unsigned LEVELS  = clog2(N);
  localparam int unsigned BusBits = level_offset(N, LEVELS + 1) * WIDTH;

  // All tree levels packed back to back; region 0 is the raw operand input.
  logic [BusBits-1:0]        bus;
  logic [LEVELS:0]           vld;
  logic [LEVELS:0]           rdy;
  logic [2*(LEVELS+1)-1:0]   ops;
  logic                      unused_last_op;

  assign bus[N*WIDTH-1:0] = I;
  assign vld[0]           = I_valid;
  assign ops[1:0]         = OP;
  assign rdy[LEVELS]      = O_ready;

  for (genvar j = 0; j < LEVELS; j++) begin : g_level
    localparam int unsigned InCount  = level_count(N, j);
    localparam int unsigned OutCount = level_count(N, j + 1);
    localparam int unsigned InOff    = level_offset(N, j) * WIDTH;
    localparam int unsigned OutOff   = level_offset(N, j + 1) * WIDTH;

    reduce_level #(
      .WIDTH    (WIDTH),
      .IN_COUNT (InCount),
      .LAST     (j == LEVELS - 1)
    ) u_level (
      .clk_i       (CLK),
      .rst_i       (RESET),
      .in_data_i   (bus[InOff +: InCount*WIDTH]),
      .in_op_i     (ops[2*j +: 2]),
      .in_valid_i  (vld[j]),
      .in_ready_o  (rdy[j]),
      .out_data_o  (bus[OutOff +: OutCount*WIDTH]),
      .out_op_o    (ops[2*(j+1) +: 2]),
      .out_valid_o (vld[j+1]),
      .out_ready_i (rdy[j+1])
    );
  end

  assign unused_last_op = ^ops[2*LEVELS +: 2];

  assign I_ready = rdy[0];
  assign O       = bus[BusBits-1 -: WIDTH];
  assign O_valid = vld[LEVELS];

endmodule
